// File: rtl/data_mem_bridge_pkg.sv
// Shared types and constants for the core data-memory bridge.
package data_mem_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

  localparam int unsigned DefaultTimeout = 16;
  localparam int unsigned CntW           = 8;

  localparam logic [3:0] MASK_W  = 4'b1111;
  localparam logic [3:0] MASK_HL = 4'b0011;
  localparam logic [3:0] MASK_HH = 4'b1100;

endpackage

// File: rtl/data_mem_bridge_align_chk.sv
// Combinational legality check of a byte-lane mask against the low address bits.
module dmem_align_chk
  import data_mem_bridge_pkg::*;
(
  input  logic [3:0] mask_i,
  input  logic [1:0] addr_i,
  output logic       legal_o
);

  always_comb begin
    legal_o = 1'b0;
    case (mask_i)
      MASK_W:                               legal_o = (addr_i == 2'b00);
      MASK_HL, MASK_HH:                     legal_o = ~addr_i[0];
      4'b0001, 4'b0010, 4'b0100, 4'b1000:   legal_o = 1'b1;
      default:                              legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/data_mem_bridge.sv
// Bridges a stalling core data port onto a request/valid memory port with
// alignment checking and a bounded response timeout.
module data_mem_bridge
  import data_mem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [3:0]        core_mask,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic [31:0]       core_rdata,
  output logic              core_stall,
  output logic              core_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_mask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_valid,
  input  logic [31:0]       mem_rdata
);

  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              we_q, we_d;
  logic [3:0]        mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              legal;
  logic              busy;

  dmem_align_chk u_align_chk (
    .mask_i  (core_mask),
    .addr_i  (core_addr[1:0]),
    .legal_o (legal)
  );

  assign cnt_inc = cnt_q + CntW'(1);
  assign busy    = (state_q == StIssue) || (state_q == StWait);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      StIdle: begin
        if (core_req) begin
          if (legal) begin
            we_d    = core_we;
            mask_d  = core_mask;
            addr_d  = {core_addr[ADDR_W-1:2], 2'b00};
            wdata_d = core_wdata;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = StIssue;
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = StDone;
          end
        end
      end
      StIssue, StWait: begin
        // A response in the timeout cycle still wins over the abort.
        if (mem_valid) begin
          err_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : mem_rdata;
          state_d = StDone;
        end else if (cnt_inc == TimeoutCnt) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StDone;
        end else begin
          cnt_d   = cnt_inc;
          state_d = StWait;
        end
      end
      StDone: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      mask_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Stall is combinational so the core freezes in the same cycle it requests.
  assign core_stall = ~rst & (((state_q == StIdle) & core_req) | busy);
  assign core_err   = ~rst & (state_q == StDone) & err_q;
  assign core_rdata = rdata_q;

  assign mem_req   = busy;
  assign mem_we    = we_q;
  assign mem_mask  = mask_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Self-checking bench for data_mem_bridge: directed scenarios plus randomized
// transactions scored against a lane/alignment/latency reference model.
module tb_data_mem_bridge;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we;
  logic [3:0]  core_mask;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_stall, core_err;
  logic        mem_req, mem_we;
  logic [3:0]  mem_mask;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_valid;
  logic [31:0] mem_rdata;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata = 32'h0;

  always #5 clk = ~clk;

  data_mem_bridge #(
    .TIMEOUT (TO),
    .ADDR_W  (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_mask  (core_mask),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .core_err   (core_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_mask   (mem_mask),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_valid  (mem_valid),
    .mem_rdata  (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Legal access: contiguous run of 1, 2 or 4 lanes aligned to its own size,
  // and the byte address aligned to the access size.
  function automatic bit model_legal(input logic [3:0] m, input logic [31:0] a);
    int n, off, span;
    n = $countones(m);
    if (!(n == 1 || n == 2 || n == 4)) return 1'b0;
    off = 0;
    for (int i = 3; i >= 0; i--) if (m[i]) off = i;
    span = ((1 << n) - 1) << off;
    return (span == int'(m)) && (off % n == 0) && (int'(a[1:0]) % n == 0);
  endfunction

  // lat: index of the mem_req cycle carrying mem_valid (>= TO means never).
  task automatic run_txn(input logic we, input logic [3:0] m, input logic [31:0] a,
                         input logic [31:0] wd, input int lat, input logic [31:0] rd,
                         input bit hold);
    bit          legal, done, held_ok;
    int          exp_stall, exp_req, stall_n, req_n;
    logic        exp_err;
    logic [31:0] exp_rd;
    legal   = model_legal(m, a);
    done    = 1'b0;
    held_ok = 1'b1;
    stall_n = 0;
    req_n   = 0;
    if (!legal) begin
      exp_stall = 1; exp_req = 0; exp_err = 1'b1; exp_rd = 32'h0;
    end else if (lat < TO) begin
      exp_stall = lat + 2; exp_req = lat + 1; exp_err = 1'b0; exp_rd = we ? 32'h0 : rd;
    end else begin
      exp_stall = TO + 1; exp_req = TO; exp_err = 1'b1; exp_rd = 32'h0;
    end

    @(negedge clk);
    mem_valid = 1'b0;
    #1;
    check("idle_err_low", 32'(core_err), 32'h0);
    check("idle_mem_req_low", 32'(mem_req), 32'h0);
    check("rdata_hold", core_rdata, last_rdata);
    core_req   = 1'b1;
    core_we    = we;
    core_mask  = m;
    core_addr  = a;
    core_wdata = wd;

    for (int c = 0; c < 60 && !done; c++) begin
      #1;
      if (mem_req) begin
        if (mem_addr !== {a[31:2], 2'b00} || mem_mask !== m || mem_we !== we ||
            mem_wdata !== wd) held_ok = 1'b0;
        if (req_n == lat) begin
          mem_valid = 1'b1;
          mem_rdata = rd;
        end else begin
          mem_rdata = $urandom;
        end
        req_n++;
      end
      if (core_stall) begin
        stall_n++;
        @(negedge clk);
        mem_valid = 1'b0;
      end else begin
        done = 1'b1;
        check("done_err", 32'(core_err), 32'(exp_err));
        check("done_rdata", core_rdata, exp_rd);
        core_req  = hold;
        // Stray response in DONE must be ignored.
        mem_valid = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
    check("done_reached", 32'(done), 32'h1);
    check("stall_cycles", stall_n, exp_stall);
    check("mem_req_cycles", req_n, exp_req);
    check("mem_fields_stable", 32'(held_ok), 32'h1);
    last_rdata = exp_rd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    logic [3:0] legal_masks [7];
    logic [3:0] m;
    legal_masks = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};

    rst        = 1'b1;
    core_req   = 1'b1;
    core_we    = 1'b0;
    core_mask  = 4'hF;
    core_addr  = 32'h0;
    core_wdata = 32'h0;
    mem_valid  = 1'b0;
    mem_rdata  = 32'h0;

    // Reset: outputs gated while rst=1 even with a request pending.
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", 32'(core_stall), 32'h0);
    check("rst_err", 32'(core_err), 32'h0);
    rst      = 1'b0;
    core_req = 1'b0;
    #1;
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_rdata", core_rdata, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_mask", 32'(mem_mask), 32'h0);

    // Load word answered in ISSUE.
    run_txn(1'b0, 4'hF, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0);
    // Store halfword with three empty WAIT-side cycles.
    run_txn(1'b1, 4'hC, 32'h202, 32'hABCD0000, 3, 32'h12345678, 1'b0);
    // Misaligned word.
    run_txn(1'b0, 4'hF, 32'h101, 32'h0, 0, 32'h11111111, 1'b0);
    // No response: timeout.
    run_txn(1'b0, 4'hF, 32'h300, 32'h0, 99, 32'h22222222, 1'b0);
    // Response in the final allowed cycle.
    run_txn(1'b0, 4'hF, 32'h304, 32'h0, TO - 1, 32'h33333333, 1'b0);
    // Request held across DONE, then a fresh transaction.
    run_txn(1'b0, 4'h3, 32'h402, 32'h0, 1, 32'h0000BEEF, 1'b1);
    run_txn(1'b0, 4'h8, 32'h503, 32'h0, 2, 32'hCAFEF00D, 1'b0);

    // Reset in WAIT, followed by a stray response.
    @(negedge clk);
    mem_valid  = 1'b0;
    core_req   = 1'b1;
    core_we    = 1'b1;
    core_mask  = 4'hF;
    core_addr  = 32'h600;
    core_wdata = 32'h5A5A5A5A;
    repeat (2) @(negedge clk);
    #1;
    check("pre_rst_mem_req", 32'(mem_req), 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_stall", 32'(core_stall), 32'h0);
    check("mid_rst_err", 32'(core_err), 32'h0);
    @(negedge clk);
    rst       = 1'b0;
    core_req  = 1'b0;
    mem_valid = 1'b1;
    mem_rdata = 32'h87654321;
    #1;
    check("post_rst_mem_req", 32'(mem_req), 32'h0);
    check("post_rst_stall", 32'(core_stall), 32'h0);
    check("post_rst_rdata", core_rdata, 32'h0);
    check("post_rst_mem_addr", mem_addr, 32'h0);
    check("post_rst_mem_wdata", mem_wdata, 32'h0);
    check("post_rst_mem_we", 32'(mem_we), 32'h0);
    @(negedge clk);
    mem_valid = 1'b0;
    #1;
    check("stray_valid_mem_req", 32'(mem_req), 32'h0);
    check("stray_valid_rdata", core_rdata, 32'h0);
    last_rdata = 32'h0;

    // Randomized transactions.
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 1) == 0) m = legal_masks[$urandom_range(0, 6)];
      else                           m = 4'($urandom);
      run_txn(1'($urandom), m, $urandom, $urandom, int'($urandom_range(0, 19)), $urandom,
              1'($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    core_req  = 1'b0;
    mem_valid = 1'b0;
    @(negedge clk);
    #1;
    check("final_err_low", 32'(core_err), 32'h0);
    check("final_rdata_hold", core_rdata, last_rdata);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
